processor_run_ctrl: RTL
=======================

Name: processor_run_ctrl

Overview:
- Synthesizable run controller that sits beside Processor and replaces the fixed clock/reset/duration sequencing with a parametrised, self-checking one.
- Stretches the core reset, gates core execution in free-run or single-step mode, and counts executed cycles.
- Terminates a run on core halt, on a cycle budget, or on a PC-stall watchdog, and reports which one fired.

Parameters:
- RESET_CYCLES, 4: clocks o_core_reset stays high after i_reset deasserts (>=1).
- CNT_W, 32: width of the cycle budget and cycle counter.
- PC_W, 32: width of the observed program counter.
- STALL_LIMIT, 16: consecutive enabled cycles with unchanged PC that declare a stall (>=2).

Ports:
- i_clk  in  1  single clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse; begins a run from IDLE
- i_clear  in  1  one-cycle pulse; leaves a terminal state
- i_mode  in  1  0 = free-run, 1 = single-step; latched on i_start
- i_step  in  1  one-cycle pulse; grants one core cycle in step mode
- i_budget  in  CNT_W  max enabled cycles; 0 = unlimited; latched on i_start
- i_halt  in  1  core halt indication
- i_pc  in  PC_W  core program counter
- o_core_reset  out  1  reset to core
- o_core_en  out  1  core clock-enable
- o_busy  out  1  high in RUN or STEP
- o_done  out  1  run ended by i_halt
- o_timeout  out  1  run ended by budget
- o_stall  out  1  run ended by PC watchdog
- o_cycles  out  CNT_W  enabled-cycle count

Behaviour:
- Reset (async, immediate without a clock edge): state=HOLD, o_core_reset=1, o_core_en=0, o_busy=o_done=o_timeout=o_stall=0, o_cycles=0, hold/stall counters=0.
- All outputs are registered.
- States: HOLD, IDLE, RUN, STEP, DONE, TIMEOUT, STALL.
- HOLD: counts edges after i_reset deasserts. On the RESET_CYCLES-th edge: o_core_reset=0 and state moves to IDLE. i_start is ignored in HOLD.
- IDLE, on i_start:
  - latch i_mode and i_budget; clear o_cycles, the flags, and the stall counter;
  - go to RUN (mode 0) or STEP (mode 1);
  - in RUN, o_core_en=1 from that same edge.
- RUN:
  - o_cycles increments on every edge where o_core_en=1, saturating at all-ones.
  - Exit checks on each enabled edge, priority order: i_halt -> DONE; else budget!=0 and o_cycles+1==budget -> TIMEOUT; else stall counter reaches STALL_LIMIT -> STALL.
  - The terminating cycle is counted. On exit, o_core_en=0 and the matching flag=1 at that edge.
- STEP:
  - An i_step sampled high sets o_core_en=1 for exactly one cycle at the next edge.
  - i_step arriving while o_core_en=1 is ignored.
  - Halt/budget checks and the counter apply only on enabled cycles. Stall detection is disabled.
- Stall counter: clears when i_pc differs from the PC registered on the previous enabled cycle; otherwise increments on each enabled cycle. The first enabled cycle of a run always clears it.
- DONE/TIMEOUT/STALL:
  - flag, o_cycles and o_core_en=0 are held;
  - i_start is ignored;
  - i_clear -> HOLD (o_core_reset=1, flags cleared, o_cycles kept until next start).
- Simultaneous events:
  - i_halt on the budget-final cycle -> DONE only.
  - i_clear and i_start together in a terminal state -> i_clear wins.
  - i_start with i_clear in IDLE -> start.
- o_busy = (state==RUN || state==STEP).
- i_reset mid-run: immediate return to reset values; o_core_en drops asynchronously.

Test Plan:
- i_reset high 2 cycles, then low -> o_core_reset falls exactly 4 edges later; all other outputs 0 throughout.
- i_start, mode 0, budget 10, i_halt low, i_pc incrementing -> o_core_en high exactly 10 cycles, then o_timeout=1, o_cycles=10, o_busy=0.
- budget 0, i_halt asserted during the 7th enabled cycle -> o_done=1, o_cycles=7, o_timeout=0; i_halt together with the budget-final cycle (budget 7) -> o_done only.
- mode 1, three i_step pulses 5 cycles apart plus one i_step while enabled -> exactly 3 one-cycle o_core_en pulses, o_cycles=3, o_busy stays 1.
- mode 0, i_pc constant at 0x40 -> o_stall=1 after 16 enabled cycles, o_cycles=16; then i_clear -> HOLD, o_core_reset high 4 cycles, flags 0.
- Run in progress with o_cycles=5, i_reset asserted mid-cycle -> o_core_en=0 and o_core_reset=1 before the next edge; o_cycles=0.

Source files
------------

// File: rtl/processor_run_ctrl.sv
// Run controller beside the processor core: stretches core reset, gates execution in
// free-run or single-step mode, counts enabled cycles and reports why a run ended.
module processor_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned STALL_LIMIT  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_mode,
  input  logic             i_step,
  input  logic [CNT_W-1:0] i_budget,
  input  logic             i_halt,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_core_reset,
  output logic             o_core_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_cycles
);

  localparam int unsigned HoldW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned StallW = $clog2(STALL_LIMIT);

  typedef enum logic [2:0] {
    StHold, StIdle, StRun, StStep, StDone, StTimeout, StStall
  } state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [StallW-1:0]  stall_q, stall_d, stall_nxt;
  logic [CNT_W-1:0]   cycles_q, cycles_d, cycles_inc;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               core_en_q, core_en_d;
  logic               budget_hit;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall_d    = stall_q;
    cycles_d   = cycles_q;
    budget_d   = budget_q;
    pc_d       = pc_q;
    core_en_d  = 1'b0;
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
    budget_hit = (budget_q != '0) && (cycles_q + CNT_W'(1) == budget_q);
    // stall_q counts repeats of the PC, so STALL_LIMIT identical cycles means LIMIT-1 repeats;
    // a zero cycle count marks the first enabled cycle of the run.
    stall_nxt  = ((cycles_q == '0) || (i_pc != pc_q)) ? '0 : stall_q + StallW'(1);

    unique case (state_q)
      StHold: begin
        if (hold_q == HoldW'(RESET_CYCLES - 1)) begin
          hold_d  = '0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StIdle: begin
        if (i_start) begin
          budget_d  = i_budget;
          cycles_d  = '0;
          stall_d   = '0;
          state_d   = i_mode ? StStep : StRun;
          core_en_d = ~i_mode;
        end
      end
      StRun: begin
        cycles_d  = cycles_inc;
        pc_d      = i_pc;
        stall_d   = stall_nxt;
        core_en_d = 1'b1;
        if (i_halt) begin
          state_d   = StDone;
          core_en_d = 1'b0;
        end else if (budget_hit) begin
          state_d   = StTimeout;
          core_en_d = 1'b0;
        end else if (stall_nxt == StallW'(STALL_LIMIT - 1)) begin
          state_d   = StStall;
          core_en_d = 1'b0;
        end
      end
      StStep: begin
        // A step request during the granted cycle is dropped, not queued.
        if (core_en_q) begin
          cycles_d = cycles_inc;
          pc_d     = i_pc;
          if (i_halt) begin
            state_d = StDone;
          end else if (budget_hit) begin
            state_d = StTimeout;
          end
        end else if (i_step) begin
          core_en_d = 1'b1;
        end
      end
      StDone, StTimeout, StStall: begin
        if (i_clear) begin
          state_d = StHold;
          hold_d  = '0;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StHold;
      hold_q       <= '0;
      stall_q      <= '0;
      cycles_q     <= '0;
      budget_q     <= '0;
      pc_q         <= '0;
      core_en_q    <= 1'b0;
      o_core_reset <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_timeout    <= 1'b0;
      o_stall      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stall_q      <= stall_d;
      cycles_q     <= cycles_d;
      budget_q     <= budget_d;
      pc_q         <= pc_d;
      core_en_q    <= core_en_d;
      o_core_reset <= (state_d == StHold);
      o_busy       <= (state_d == StRun) || (state_d == StStep);
      o_done       <= (state_d == StDone);
      o_timeout    <= (state_d == StTimeout);
      o_stall      <= (state_d == StStall);
    end
  end

  assign o_core_en = core_en_q;
  assign o_cycles  = cycles_q;

endmodule
